ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder_if.sv | 16 +
 rtl/ram_responder.sv | 139 +++++++++++++
 tb/tb_ram_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ram_responder_if.sv
// Request/response bus between an MAR/MDR-style requester and the ram_responder.
interface ram_responder_if;
  logic        Read;
  logic        Write;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] Mdatain;
  logic        Busy;
  logic        Done;
  logic        AddrErr;

  modport master (output Read, Write, Address, DataIn,
                  input  Mdatain, Busy, Done, AddrErr);
  modport slave  (input  Read, Write, Address, DataIn,
                  output Mdatain, Busy, Done, AddrErr);
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM behind a Read/Write strobe handshake with a fixed number of wait
// states, a one-cycle Done pulse and an AddrErr flag for out-of-range or conflicting requests.
module ram_responder #(
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic          Clock,
  input  logic          Clear,
  ram_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [31:0]     mdat_q, mdat_d;

  logic [31:0]     mem [0:DEPTH-1];

  logic            finish;
  logic            addr_ok;
  logic            conflict;
  logic            mem_we;
  logic [31:0]     mem_rdata;

  // Every decision at completion uses only the latched request, never live inputs.
  assign finish    = (state_q == S_WAIT) && (cnt_q == '0);
  assign addr_ok   = (addr_q[31:ADDR_BITS] == '0);
  assign conflict  = rd_q & wr_q;
  assign mem_we    = finish & wr_q & ~rd_q & addr_ok;
  assign mem_rdata = mem[addr_q[ADDR_BITS-1:0]];

  // State register and all registered outputs.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mdat_q  <= mdat_d;
    end
  end

  // Storage survives Clear; an abandoned request never reaches the write enable.
  always_ff @(posedge Clock) begin
    if (mem_we) mem[addr_q[ADDR_BITS-1:0]] <= data_q;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.Read || bus.Write) state_d = S_WAIT;
      S_WAIT: if (cnt_q == '0)           state_d = S_DONE;
      S_DONE:                            state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    mdat_d = mdat_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.Read || bus.Write) begin
          addr_d = bus.Address;
          data_d = bus.DataIn;
          rd_d   = bus.Read;
          wr_d   = bus.Write;
          cnt_d  = CNT_W'(WAIT_STATES);
          busy_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
          err_d  = conflict | ~addr_ok;
          // A conflicting request leaves Mdatain alone; an out-of-range read returns zero.
          if (rd_q && !conflict) mdat_d = addr_ok ? mem_rdata : 32'h0;
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    endcase
  end

  assign bus.Mdatain = mdat_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.AddrErr = err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench: one responder with 2 wait states, one with none, sharing clock and Clear.
module tb_ram_responder;

  logic clk;
  logic clr;
  int   ntests;
  int   nfail;

  ram_responder_if ifa ();
  ram_responder_if ifb ();

  ram_responder #(.ADDR_BITS(9), .WAIT_STATES(2)) dut_a (.Clock(clk), .Clear(clr), .bus(ifa));
  ram_responder #(.ADDR_BITS(9), .WAIT_STATES(0)) dut_b (.Clock(clk), .Clear(clr), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on dut_a; strobes drop right after acceptance, Done latency counted in edges.
  task automatic run_a(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data, input bit scramble,
                       input logic exp_err, input logic [31:0] exp_mdat);
    int lat;
    ifa.Read = rd; ifa.Write = wr; ifa.Address = addr; ifa.DataIn = data;
    @(posedge clk); #1;
    ifa.Read = 1'b0; ifa.Write = 1'b0;
    chk({tag, " busy"}, {31'b0, ifa.Busy}, 32'd1);
    lat = 0;
    while (ifa.Done !== 1'b1 && lat < 40) begin
      if (scramble) begin ifa.Address = $urandom; ifa.DataIn = $urandom; end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, 32'd3);
    chk({tag, " busy@done"}, {31'b0, ifa.Busy}, 32'd0);
    chk({tag, " err"}, {31'b0, ifa.AddrErr}, {31'b0, exp_err});
    chk({tag, " mdat"}, ifa.Mdatain, exp_mdat);
    @(posedge clk); #1;
    chk({tag, " done drop"}, {30'b0, ifa.Done, ifa.AddrErr}, 32'd0);
  endtask

  initial begin
    int ndone;
    ntests = 0; nfail = 0;
    clr = 1'b0;
    ifa.Read = 0; ifa.Write = 0; ifa.Address = 0; ifa.DataIn = 0;
    ifb.Read = 0; ifb.Write = 0; ifb.Address = 0; ifb.DataIn = 0;
    #1;
    chk("reset a", {ifa.Busy, ifa.Done, ifa.AddrErr}, 32'd0);
    chk("reset a mdat", ifa.Mdatain, 32'd0);
    chk("reset b", {ifb.Busy, ifb.Done, ifb.AddrErr}, 32'd0);
    @(posedge clk); #1;
    clr = 1'b1;

    // Basic write/read round trip and data seeding.
    run_a("wr 005", 1'b0, 1'b1, 32'h005, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    run_a("rd 005", 1'b1, 1'b0, 32'h005, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF);
    run_a("wr 000", 1'b0, 1'b1, 32'h000, 32'hA5A50000, 1'b0, 1'b0, 32'hDEADBEEF);
    run_a("wr 00A", 1'b0, 1'b1, 32'h00A, 32'h0BADF00D, 1'b0, 1'b0, 32'hDEADBEEF);

    // Out-of-range accesses.
    run_a("rd 200", 1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 1'b1, 32'h0);
    run_a("wr 200", 1'b0, 1'b1, 32'h200, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0);
    run_a("rd 000", 1'b1, 1'b0, 32'h000, 32'h0,        1'b0, 1'b0, 32'hA5A50000);
    run_a("rd high", 1'b1, 1'b0, 32'h8000_0005, 32'h0,  1'b0, 1'b1, 32'h0);
    run_a("rd 000b", 1'b1, 1'b0, 32'h000, 32'h0,       1'b0, 1'b0, 32'hA5A50000);

    // Conflicting strobes: no access, Mdatain keeps the last read.
    run_a("rdwr 005", 1'b1, 1'b1, 32'h005, 32'h11111111, 1'b0, 1'b1, 32'hA5A50000);
    run_a("rd 005b", 1'b1, 1'b0, 32'h005, 32'h0,         1'b0, 1'b0, 32'hDEADBEEF);

    // Clear in the middle of a write.
    ifa.Write = 1'b1; ifa.Address = 32'h00A; ifa.DataIn = 32'h12345678;
    @(posedge clk); #1;
    ifa.Write = 1'b0;
    chk("clr busy pre", {31'b0, ifa.Busy}, 32'd1);
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    chk("clr flags", {ifa.Busy, ifa.Done, ifa.AddrErr}, 32'd0);
    chk("clr mdat", ifa.Mdatain, 32'd0);
    #2 clr = 1'b1;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ifa.Done === 1'b1 || ifa.Busy === 1'b1) ndone++;
    end
    chk("clr no done", ndone, 32'd0);
    run_a("rd 00A", 1'b1, 1'b0, 32'h00A, 32'h0, 1'b0, 1'b0, 32'h0BADF00D);

    // Inputs churn during WAIT; latched values must win.
    run_a("wr 00C scr", 1'b0, 1'b1, 32'h00C, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0BADF00D);
    run_a("rd 00C scr", 1'b1, 1'b0, 32'h00C, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D);

    // Zero wait states: seed 0x1FF, then back-to-back reads with Read held high.
    ifb.Write = 1'b1; ifb.Address = 32'h1FF; ifb.DataIn = 32'h600DCAFE;
    @(posedge clk); #1;
    ifb.Write = 1'b0;
    @(posedge clk); #1;
    chk("b wr done", {ifb.Done, ifb.AddrErr}, 32'd2);
    @(posedge clk); #1;
    ifb.Read = 1'b1;
    @(posedge clk); #1;
    chk("b rd1 busy", {ifb.Busy, ifb.Done}, 32'd2);
    @(posedge clk); #1;
    chk("b rd1 done", {ifb.Busy, ifb.Done, ifb.AddrErr}, 32'd2);
    chk("b rd1 mdat", ifb.Mdatain, 32'h600DCAFE);
    @(posedge clk); #1;
    chk("b idle gap", {ifb.Busy, ifb.Done}, 32'd0);
    @(posedge clk); #1;
    ifb.Read = 1'b0;
    chk("b rd2 accept", {ifb.Busy, ifb.Done}, 32'd2);
    @(posedge clk); #1;
    chk("b rd2 done", {ifb.Busy, ifb.Done, ifb.AddrErr}, 32'd2);
    chk("b rd2 mdat", ifb.Mdatain, 32'h600DCAFE);
    @(posedge clk); #1;
    chk("b rd2 drop", {ifb.Busy, ifb.Done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
